// File: rtl/quant_sched.sv
// quant_sched: round-robin job scheduler sharing one requantization engine
// among NUM_REQ tile requesters.
//
// Optional build macro: QUANT_SCHED_TIMEOUT_EN (adds the START/WAIT timeout
// counter and the err_o pulse; when undefined err_o is tied to 0).
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   req_i        per-requester job request (level)
//   scale_in_i   per-requester scale factor, requester k at [k*ACC_WIDTH +: ACC_WIDTH]
//   shift_in_i   per-requester shift amount, requester k at [k*8 +: 8]
//   grant_o      one-hot owner of the engine (0 in IDLE)
//   done_o       one-hot 1-cycle completion pulse
//   err_o        one-hot 1-cycle timeout pulse
//   busy_o       scheduler not idle
//   q_enable_o   engine enable (edge-detected by the engine)
//   q_scale_o    latched scale factor to the engine
//   q_shift_o    latched shift amount to the engine
//   q_sel_o      accumulator-mux select for the engine data input
//   q_valid_i    engine result valid
module quant_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ACC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*ACC_WIDTH-1:0] scale_in_i,
  input  logic [NUM_REQ*8-1:0]         shift_in_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [NUM_REQ-1:0]           err_o,
  output logic                         busy_o,
  output logic                         q_enable_o,
  output logic [ACC_WIDTH-1:0]         q_scale_o,
  output logic [7:0]                   q_shift_o,
  output logic [$clog2(NUM_REQ)-1:0]   q_sel_o,
  input  logic                         q_valid_i
);

  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_REL} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [ACC_WIDTH-1:0] scale_q, scale_d;
  logic [7:0]           shift_q, shift_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 rel_q, rel_d;
  logic                 busy_q, en_q;

  logic                 found;
  logic [SEL_W-1:0]     win, cand;

`ifdef QUANT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    scale_d = scale_q;
    shift_d = shift_q;
    grant_d = grant_q;
    done_d  = '0;
    rel_d   = rel_q;
    found   = 1'b0;
    win     = '0;
    cand    = '0;
`ifdef QUANT_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif

    // Round-robin search starting just after the previous winner, so a
    // requester that keeps req high after done drops to lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = SEL_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          last_d  = win;
          sel_d   = win;
          scale_d = scale_in_i[int'(win)*ACC_WIDTH +: ACC_WIDTH];
          shift_d = shift_in_i[int'(win)*8 +: 8];
          grant_d = NUM_REQ'(1) << win;
`ifdef QUANT_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_START, S_WAIT: begin
`ifdef QUANT_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A valid in the same cycle as the timeout takes precedence.
        if (q_valid_i) begin
          done_d  = grant_q;
          state_d = S_REL;
          rel_d   = 1'b0;
        end
`ifdef QUANT_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          err_d   = grant_q;
          state_d = S_REL;
          rel_d   = 1'b0;
        end
`endif
        else begin
          state_d = S_WAIT;
        end
      end
      S_REL: begin
        // Two cycles with enable low so the engine sees a clean falling edge.
        if (rel_q) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          rel_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= SEL_W'(NUM_REQ - 1);
      sel_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      scale_q <= scale_d;
      shift_q <= shift_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rel_q   <= rel_d;
      busy_q  <= (state_d != S_IDLE);
      en_q    <= (state_d == S_START) || (state_d == S_WAIT);
    end
  end

`ifdef QUANT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign q_enable_o = en_q;
  assign q_scale_o  = scale_q;
  assign q_shift_o  = shift_q;
  assign q_sel_o    = sel_q;

endmodule
